// File: rtl/snn_pkg.sv
// Shared constants and event word layout for the spike capture path.
// Latency: n/a. Backpressure: n/a.
package snn_pkg;
  localparam int POT_W      = 5;
  localparam int TS_W_DEF   = 11;
  localparam int DEPTH_DEF  = 8;
  localparam int DROP_W_DEF = 8;

  typedef struct packed {
    logic [TS_W_DEF-1:0] ts;
    logic [POT_W-1:0]    pot;
  } spike_evt_t;
endpackage

// File: rtl/spike_event_logger_if.sv
// Event drain handshake: head-of-FIFO event word with valid/ready.
// Latency: n/a. Backpressure: consumer holds out_ready low to stall the head.
interface spike_event_logger_if
  import snn_pkg::*;
#(
  parameter int TS_W = TS_W_DEF
);
  logic                  out_valid;
  logic                  out_ready;
  logic [TS_W+POT_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/spike_fifo.sv
// Synchronous register-array FIFO with wrap-bit pointers and a registered level.
// Latency: 1 cycle push-to-dout. Backpressure: push accepted when full only with a same-cycle pop.
module spike_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      mem    <= '{default: '0};
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + ONE;
      end
      if (do_push != do_pop) begin
        level <= do_push ? level + ONE : level - ONE;
      end
    end
  end

  // Same address with differing wrap bits means the writer has lapped the reader.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/spike_event_logger.sv
// Timestamps neuron spike onsets with the pre-fire potential and queues them for readout.
// Latency: event visible 1 cycle after detect. Backpressure: none to the neuron; full FIFO drops and counts.
module spike_event_logger
  import snn_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int TS_W   = TS_W_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spike_in,
  input  logic [POT_W-1:0]         state_in,
  input  logic                     clr_stats,
  spike_event_logger_if.master     evt_if,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count
);
  logic [TS_W-1:0]  ts;
  logic             spike_q;
  logic [POT_W-1:0] state_q;
  logic             evt;
  logic             pop;
  logic             push;
  logic             drop;
  logic             full;
  logic             empty;

  assign evt  = spike_in & ~spike_q;
  assign pop  = evt_if.out_valid & evt_if.out_ready;
  assign push = evt & (~full | pop);
  assign drop = evt & full & ~pop;

  assign evt_if.out_valid = ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      ts      <= '0;
      spike_q <= 1'b0;
      state_q <= '0;
    end else begin
      ts      <= ts + TS_W'(1);
      spike_q <= spike_in;
      state_q <= state_in;
    end
  end

  // A drop coinciding with a clear restarts the count at one so the loss is not hidden.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_stats) begin
        drop_count <= DROP_W'(1);
      end else if (drop_count != '1) begin
        drop_count <= drop_count + DROP_W'(1);
      end
    end else if (clr_stats) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  spike_fifo #(
    .W     (TS_W + POT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({ts, state_q}),
    .dout  (evt_if.out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );
endmodule

// File: tb/tb_spike_event_logger.sv
// Scoreboard bench for spike_event_logger with a narrow timestamp so wrap is reachable.
// Expected event words are queued at stimulus time and compared as the DUT presents them.
module tb_spike_event_logger;
  import snn_pkg::*;

  localparam int DEPTH  = 8;
  localparam int TS_W   = 4;
  localparam int DROP_W = 8;
  localparam int W      = TS_W + POT_W;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              spike_in;
  logic [POT_W-1:0]  state_in;
  logic              clr_stats;
  logic [LW-1:0]     level;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  spike_event_logger_if #(.TS_W(TS_W)) evt_if ();

  always #5 clk = ~clk;

  spike_event_logger #(
    .DEPTH  (DEPTH),
    .TS_W   (TS_W),
    .DROP_W (DROP_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .spike_in   (spike_in),
    .state_in   (state_in),
    .clr_stats  (clr_stats),
    .evt_if     (evt_if),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0]      exp_q[$];
  logic [TS_W-1:0]   ts_m;
  logic              spk_prev;
  logic [POT_W-1:0]  st_prev;
  logic              ovf_m;
  logic [DROP_W-1:0] dc_m;
  logic [W-1:0]      word;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock of stimulus; outputs checked before and after the edge.
  task automatic cyc(input logic spk, input logic [POT_W-1:0] st, input logic rdy,
                     input logic clr = 1'b0, input logic rst = 1'b0);
    logic evt, pop, full_m;
    spike_in         = spk;
    state_in         = st;
    evt_if.out_ready = rdy;
    clr_stats        = clr;
    reset            = rst;
    chk("out_valid", {31'd0, evt_if.out_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) chk("out_data", 32'(evt_if.out_data), 32'(exp_q[0]));
    pop    = rdy && (exp_q.size() != 0);
    evt    = spk && !spk_prev;
    full_m = (exp_q.size() == DEPTH);
    if (rst) begin
      exp_q.delete();
      ovf_m = 1'b0;
      dc_m  = '0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (evt && (!full_m || pop)) exp_q.push_back({ts_m, st_prev});
      if (evt && full_m && !pop) begin
        ovf_m = 1'b1;
        if (clr) dc_m = 1;
        else if (dc_m != '1) dc_m = dc_m + 1'b1;
      end else if (clr) begin
        ovf_m = 1'b0;
        dc_m  = '0;
      end
    end
    @(posedge clk);
    ts_m     = rst ? '0 : ts_m + 1'b1;
    spk_prev = rst ? 1'b0 : spk;
    st_prev  = rst ? '0 : st;
    #1;
    chk("level", 32'(level), 32'(exp_q.size()));
    chk("overflow", {31'd0, overflow}, {31'd0, ovf_m});
    chk("drop_count", 32'(drop_count), 32'(dc_m));
  endtask

  task automatic pulse(input logic [POT_W-1:0] pot, input logic rdy = 1'b0, input logic clr = 1'b0);
    cyc(1'b0, pot, 1'b0);
    cyc(1'b1, pot, rdy, clr);
    cyc(1'b0, pot, 1'b0);
    cyc(1'b0, pot, 1'b0);
  endtask

  initial begin
    reset            = 1'b1;
    spike_in         = 1'b0;
    state_in         = '0;
    clr_stats        = 1'b0;
    evt_if.out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    ts_m = '0; spk_prev = 1'b0; st_prev = '0; ovf_m = 1'b0; dc_m = '0;

    chk("rst_valid", {31'd0, evt_if.out_valid}, 32'd0);
    chk("rst_data", 32'(evt_if.out_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_ts", 32'(dut.ts), 32'd0);

    // First event: spike at ts=5 carries the potential seen at ts=4.
    for (int i = 0; i < 4; i++) cyc(1'b0, 5'd7, 1'b0);
    cyc(1'b0, 5'd9, 1'b0);
    cyc(1'b1, 5'd9, 1'b0);
    word = {4'd5, 5'd9};
    chk("t1_valid", {31'd0, evt_if.out_valid}, 32'd1);
    chk("t1_data", 32'(evt_if.out_data), 32'(word));
    chk("t1_level", 32'(level), 32'd1);
    cyc(1'b0, 5'd9, 1'b1);
    cyc(1'b0, 5'd0, 1'b0);

    // Held level yields a single event.
    for (int i = 0; i < 20; i++) cyc(1'b1, 5'd3, 1'b0);
    cyc(1'b0, 5'd3, 1'b0);
    chk("hold_level", 32'(level), 32'd1);
    cyc(1'b0, 5'd0, 1'b1);

    // Fill, overflow by two, then a drop coinciding with a clear.
    for (int p = 0; p < 8; p++) pulse(5'(p + 10));
    chk("fill_level", 32'(level), 32'd8);
    pulse(5'd20);
    pulse(5'd21);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_drop2", 32'(drop_count), 32'd2);
    chk("ovf_level", 32'(level), 32'd8);
    pulse(5'd22, 1'b0, 1'b1);
    chk("clrdrop_cnt", 32'(drop_count), 32'd1);
    chk("clrdrop_ovf", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 9; i++) cyc(1'b0, 5'd0, 1'b1);
    chk("drain_level", 32'(level), 32'd0);

    // Full FIFO with a pop coinciding with the ninth event.
    cyc(1'b0, 5'd0, 1'b0, 1'b1);
    chk("clr_drop", 32'(drop_count), 32'd0);
    chk("clr_ovf", {31'd0, overflow}, 32'd0);
    for (int p = 0; p < 8; p++) pulse(5'(p + 1));
    pulse(5'd30, 1'b1);
    chk("swap_drop", 32'(drop_count), 32'd0);
    chk("swap_level", 32'(level), 32'd8);
    chk("swap_ovf", {31'd0, overflow}, 32'd0);

    // Reset with three entries still buffered.
    for (int i = 0; i < 5; i++) cyc(1'b0, 5'd0, 1'b1);
    chk("pre_rst_level", 32'(level), 32'd3);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_valid", {31'd0, evt_if.out_valid}, 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_ts", 32'(dut.ts), 32'd0);

    // Timestamp wrap: spikes at ts=15 and ts=2.
    for (int i = 0; i < 20 && ts_m != 4'd15; i++) cyc(1'b0, 5'd6, 1'b0);
    chk("wrap_reach", 32'(ts_m), 32'd15);
    cyc(1'b1, 5'd6, 1'b0);
    cyc(1'b0, 5'd6, 1'b0);
    cyc(1'b0, 5'd8, 1'b0);
    cyc(1'b1, 5'd8, 1'b0);
    cyc(1'b0, 5'd0, 1'b0);
    word = {4'd15, 5'd6};
    chk("wrap_first", 32'(evt_if.out_data), 32'(word));
    chk("wrap_level", 32'(level), 32'd2);
    cyc(1'b0, 5'd0, 1'b1);
    word = {4'd2, 5'd8};
    chk("wrap_second", 32'(evt_if.out_data), 32'(word));
    cyc(1'b0, 5'd0, 1'b1);
    cyc(1'b0, 5'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spike_event_logger.md
# spike_event_logger

Downstream capture stage for the leaky integrate-and-fire neuron. Watches the neuron's spike output and membrane potential, turns each spike onset into a timestamped event word, and buffers the events in a small FIFO. A valid/ready interface drains the FIFO toward the readout/debug path. Overflow is counted rather than stalling the neuron, because the neuron has no back-pressure input.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries; must be a power of two, minimum 2.
- `TS_W`, default 11: timestamp width in bits.
- `DROP_W`, default 8: dropped-event counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `spike_in`  in  1  neuron spike output, level.
- `state_in`  in  5  neuron membrane potential.
- `clr_stats`  in  1  synchronous clear of `overflow` and `drop_count`.
- `out_valid`  out  1  FIFO head holds an event.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `out_data`  out  TS_W+5  event word, `{timestamp, pre_spike_potential}`.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky: an event was lost.
- `drop_count`  out  DROP_W  lost events, saturating.

## Operation
- Free-running `ts` counter, width TS_W.
  - Increments every cycle when not in reset.
  - Wraps from 2^TS_W-1 to 0. No wrap indication.
- Registered `spike_q` and `state_q` sample `spike_in` and `state_in` every cycle.
- Event condition: `spike_in==1 && spike_q==0` (rising edge only).
  - A level held high produces exactly one event.
- Event word: `{ts, state_q}`.
  - `ts` is the counter value in the detect cycle.
  - `state_q` is the potential one cycle before the edge, i.e. the pre-fire value.
- Push: occurs on an event when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- Pop: occurs when `out_valid && out_ready`.
- Drop: an event with the FIFO full and no simultaneous pop.
  - Sets `overflow`.
  - Increments `drop_count`, saturating at 2^DROP_W-1.
  - The FIFO contents are unchanged.
- `clr_stats`:
  - Clears `overflow` and `drop_count`.
  - A drop in the same cycle wins: the result is `overflow=1`, `drop_count=1`.
- Empty FIFO with a push: no same-cycle bypass.
- Ordering: strictly first in, first out.
- `out_data` is stable while `out_valid && !out_ready`.

## Timing
- Reset values:
  - `ts=0`, `spike_q=0`, `state_q=0`.
  - FIFO empty, `out_valid=0`, `out_data=0`, `level=0`.
  - `overflow=0`, `drop_count=0`.
- Reset asserted mid-operation discards all buffered events on that edge.
- Latency: spike rising at edge-sampled cycle t gives `out_valid=1` in cycle t+1.
- Pop at cycle t exposes the next entry in cycle t+1, or drops `out_valid` if the FIFO is now empty.
- `level` is registered and changes on the same edge as the push or pop.
  - A simultaneous push and pop leaves it unchanged.
- Maximum sustainable event rate is one per 2 cycles, set by the edge condition.
- Full throughput is required: push and pop every cycle, with no bubble.

## Structure
- Package `snn_pkg` holds:
  - `POT_W=5`;
  - the event word typedef `{ts, pot}`;
  - default `TS_W`, `DEPTH` and `DROP_W` constants.
- Sub-module `spike_fifo`:
  - synchronous FIFO, register array, pointers one bit wider than the address;
  - ports: `push`, `pop`, `din`, `dout`, `full`, `empty`, `level`.
- The top level owns:
  - edge detect;
  - the timestamp counter;
  - drop/overflow logic;
  - the push-when-full-with-pop rule.

## Test plan
- Reset release, `state_in=7`, `spike_in` rises at ts=5 with `state_in` already 9 at ts=4, `out_ready=0` -> `out_valid=1` next cycle, `out_data={5,9}`, `level=1`.
- `spike_in` held high for 20 cycles -> exactly one event.
- 8 spike pulses, one every 4 cycles, `out_ready=0`, DEPTH=8, followed by a 9th and 10th pulse:
  - after the 8th pulse: `level=8`;
  - after the 10th pulse: `overflow=1`, `drop_count=2`;
  - draining yields the first 8 timestamps in order.
- FIFO full, 9th event coincides with `out_ready=1` -> event accepted, `drop_count=0`, `level` stays 8.
- Counter wrap with TS_W=4: a spike at ts=15 then a spike 3 cycles later -> stored timestamps 15 then 2.
- Checks around clear and reset:
  - `clr_stats` in the same cycle as a drop gives `drop_count=1`, `overflow=1`;
  - `reset` with 3 entries buffered gives `out_valid=0`, `level=0`, `ts=0` next cycle.
